// File: rtl/mmu_pkg.sv
// Shared MMU types and constants.
// Holds the owner tag used by the dmem arbiter's in-flight ID FIFO, the
// arbiter FSM states, and the memory command/type encodings the PTW issues.
package mmu_pkg;

    typedef enum logic {
        OWN_PTW = 1'b0,
        OWN_LSU = 1'b1
    } dmem_owner_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOCK_PTW,
        S_LOCK_LSU
    } dmem_arb_state_e;

    // Memory command: integer load. Memory type: doubleword.
    localparam logic [4:0] M_XRD = 5'b00000;
    localparam logic [3:0] MT_D  = 4'b0011;

endpackage

// File: rtl/ptw_dmem_arb_fifo.sv
// Owner-ID FIFO for the PTW/LSU dmem arbiter.
// One entry per in-flight dcache request, recording who issued it so that
// responses (which return in order) can be routed back.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push, din    : enqueue an owner (ignored while full)
//   pop          : dequeue the head (ignored while empty)
//   full, empty  : occupancy flags
//   head         : owner of the oldest in-flight request
module ptw_dmem_arb_fifo
    import mmu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push,
    input  dmem_owner_e din,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output dmem_owner_e head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = dmem_owner_e'(mem[rd_ptr]);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ptw_dmem_arb.sv
// Arbiter sharing the single L1 dcache request/response port between the
// page-table walker and the load-store unit.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   ptw_req_*         : PTW request (always physical); ready = accepted
//   ptw_resp_*        : response/nack routed to the PTW
//   lsu_req_*         : LSU request; ready = accepted
//   lsu_resp_*        : response/nack routed to the LSU
//   resp_data_o       : dcache response data, broadcast to both
//   dmem_req_*        : request to the dcache (kill tied low)
//   dmem_ready_i      : dcache accepts the request this cycle
//   dmem_resp_*       : dcache response/nack, in request order
//   unexpected_resp_o : sticky, a response arrived with nothing in flight
//   pmu_lsu_stall_o   : LSU valid but not accepted this cycle
module ptw_dmem_arb
    import mmu_pkg::*;
#(
    parameter int ADDR_W       = 40,
    parameter int DATA_W       = 64,
    parameter int MAX_OUTST    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ptw_req_valid_i,
    input  logic [ADDR_W-1:0] ptw_req_addr_i,
    input  logic [4:0]        ptw_req_cmd_i,
    input  logic [3:0]        ptw_req_typ_i,
    input  logic [DATA_W-1:0] ptw_req_data_i,
    output logic              ptw_req_ready_o,
    output logic              ptw_resp_valid_o,
    output logic              ptw_resp_nack_o,
    input  logic              lsu_req_valid_i,
    input  logic [ADDR_W-1:0] lsu_req_addr_i,
    input  logic [4:0]        lsu_req_cmd_i,
    input  logic [3:0]        lsu_req_typ_i,
    input  logic [DATA_W-1:0] lsu_req_data_i,
    input  logic              lsu_req_phys_i,
    output logic              lsu_req_ready_o,
    output logic              lsu_resp_valid_o,
    output logic              lsu_resp_nack_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              dmem_req_valid_o,
    output logic [ADDR_W-1:0] dmem_req_addr_o,
    output logic [4:0]        dmem_req_cmd_o,
    output logic [3:0]        dmem_req_typ_o,
    output logic [DATA_W-1:0] dmem_req_data_o,
    output logic              dmem_req_phys_o,
    output logic              dmem_req_kill_o,
    input  logic              dmem_ready_i,
    input  logic              dmem_resp_valid_i,
    input  logic              dmem_resp_nack_i,
    input  logic [DATA_W-1:0] dmem_resp_data_i,
    output logic              unexpected_resp_o,
    output logic              pmu_lsu_stall_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    dmem_arb_state_e state, state_nxt;
    dmem_owner_e     owner;
    dmem_owner_e     head;
    logic            req_valid;
    logic            xfer;
    logic            lsu_xfer;
    logic            fifo_full;
    logic            fifo_empty;
    logic            resp_any;
    logic            pop;
    logic [SW-1:0]   starve_cnt;

    // Grant selection. A lock state keeps driving the same requester until it
    // is accepted or withdraws, so the dcache never sees a request change
    // under it while stalled.
    always_comb begin
        state_nxt = state;
        req_valid = 1'b0;
        owner     = OWN_PTW;
        case (state)
            S_IDLE: begin
                if (!fifo_full && (ptw_req_valid_i || lsu_req_valid_i)) begin
                    req_valid = 1'b1;
                    if (lsu_req_valid_i && (!ptw_req_valid_i || starve_cnt == STARVE_MAX))
                        owner = OWN_LSU;
                    if (!dmem_ready_i)
                        state_nxt = (owner == OWN_LSU) ? S_LOCK_LSU : S_LOCK_PTW;
                end
            end
            S_LOCK_PTW: begin
                owner = OWN_PTW;
                if (!ptw_req_valid_i) begin
                    state_nxt = S_IDLE;
                end else if (!fifo_full) begin
                    req_valid = 1'b1;
                    if (dmem_ready_i) state_nxt = S_IDLE;
                end
            end
            S_LOCK_LSU: begin
                owner = OWN_LSU;
                if (!lsu_req_valid_i) begin
                    state_nxt = S_IDLE;
                end else if (!fifo_full) begin
                    req_valid = 1'b1;
                    if (dmem_ready_i) state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    assign xfer     = req_valid && dmem_ready_i;
    assign lsu_xfer = xfer && (owner == OWN_LSU);

    assign dmem_req_valid_o = req_valid;
    assign dmem_req_addr_o  = (owner == OWN_LSU) ? lsu_req_addr_i : ptw_req_addr_i;
    assign dmem_req_cmd_o   = (owner == OWN_LSU) ? lsu_req_cmd_i  : ptw_req_cmd_i;
    assign dmem_req_typ_o   = (owner == OWN_LSU) ? lsu_req_typ_i  : ptw_req_typ_i;
    assign dmem_req_data_o  = (owner == OWN_LSU) ? lsu_req_data_i : ptw_req_data_i;
    assign dmem_req_phys_o  = (owner == OWN_LSU) ? lsu_req_phys_i : 1'b1;
    assign dmem_req_kill_o  = 1'b0;

    assign ptw_req_ready_o = xfer && (owner == OWN_PTW);
    assign lsu_req_ready_o = lsu_xfer;
    assign pmu_lsu_stall_o = lsu_req_valid_i && !lsu_xfer;

    // Counts how long the LSU has been left waiting; at the limit it beats
    // the PTW in the next idle arbitration.
    always_ff @(posedge clk_i) begin
        if (rst_i)                                starve_cnt <= '0;
        else if (!lsu_req_valid_i || lsu_xfer)    starve_cnt <= '0;
        else if (starve_cnt != STARVE_MAX)        starve_cnt <= starve_cnt + 1'b1;
    end

    ptw_dmem_arb_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (xfer),
        .din   (owner),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // A nack also retires the head; it takes precedence over valid.
    assign resp_any = dmem_resp_valid_i || dmem_resp_nack_i;
    assign pop      = resp_any && !fifo_empty;

    assign ptw_resp_valid_o = pop && (head == OWN_PTW) && !dmem_resp_nack_i;
    assign ptw_resp_nack_o  = pop && (head == OWN_PTW) &&  dmem_resp_nack_i;
    assign lsu_resp_valid_o = pop && (head == OWN_LSU) && !dmem_resp_nack_i;
    assign lsu_resp_nack_o  = pop && (head == OWN_LSU) &&  dmem_resp_nack_i;
    assign resp_data_o      = dmem_resp_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i)                        unexpected_resp_o <= 1'b0;
        else if (resp_any && fifo_empty)  unexpected_resp_o <= 1'b1;
    end

endmodule
